// File: rtl/button_debounce_multi_if.sv
// Button conditioner bus: raw button levels in, debounced level and event pulses out.
// The board/pin side is the master; the conditioner is the slave.
interface button_debounce_multi_if #(
    parameter int CHANNELS = 4
);
    logic [CHANNELS-1:0] button_input;
    logic [CHANNELS-1:0] button_output;
    logic [CHANNELS-1:0] button_pressed;
    logic [CHANNELS-1:0] button_released;
    logic [CHANNELS-1:0] button_repeat;

    modport master (
        output button_input,
        input  button_output,
        input  button_pressed,
        input  button_released,
        input  button_repeat
    );

    modport slave (
        input  button_input,
        output button_output,
        output button_pressed,
        output button_released,
        output button_repeat
    );
endinterface

// File: rtl/button_debounce_multi.sv
// Multi-channel button conditioner: synchroniser, stability filter, press/release
// pulses and hold-to-repeat pulses, replicated independently per channel.
module button_debounce_multi #(
    parameter int CHANNELS      = 4,
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = 1000000,
    parameter int REPEAT_DELAY  = 50000000,
    parameter int REPEAT_PERIOD = 10000000
) (
    input logic                   clk,
    input logic                   reset,
    button_debounce_multi_if.slave bus
);

    localparam int STAB_W = $clog2(STABLE_CYCLES + 1);
    localparam logic [STAB_W-1:0] STAB_LAST = STAB_W'(STABLE_CYCLES - 1);

    localparam int REP_SPAN = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int REP_W    = (REP_SPAN > 1) ? $clog2(REP_SPAN + 1) : 1;
    localparam logic [REP_W-1:0] DELAY_LAST  = REP_W'((REPEAT_DELAY > 0) ? REPEAT_DELAY - 1 : 0);
    localparam logic [REP_W-1:0] PERIOD_LAST = REP_W'(REPEAT_PERIOD - 1);
    localparam bit REPEAT_EN = (REPEAT_DELAY != 0);

    logic [SYNC_STAGES-1:0] sync_q   [CHANNELS];
    logic [STAB_W-1:0]      stab_cnt [CHANNELS];
    logic [REP_W-1:0]       rep_cnt  [CHANNELS];
    logic [CHANNELS-1:0]    rep_first;

    logic [CHANNELS-1:0] out_q;
    logic [CHANNELS-1:0] press_q;
    logic [CHANNELS-1:0] release_q;
    logic [CHANNELS-1:0] repeat_q;

    logic [CHANNELS-1:0] accept;
    logic [CHANNELS-1:0] rep_due;

    // NOTE: every variable written here gets a default first so no latch is inferred.
    always_comb begin
        accept  = '0;
        rep_due = '0;
        for (int ch = 0; ch < CHANNELS; ch++) begin
            accept[ch]  = (sync_q[ch][SYNC_STAGES-1] != out_q[ch]) && (stab_cnt[ch] == STAB_LAST);
            rep_due[ch] = rep_first[ch] ? (rep_cnt[ch] == DELAY_LAST)
                                        : (rep_cnt[ch] == PERIOD_LAST);
        end
    end

    // NOTE: the synchroniser and counters are cleared by reset too, so a button held
    // across reset is seen as a fresh press with the full latency.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int ch = 0; ch < CHANNELS; ch++) begin
                sync_q[ch]   <= '0;
                stab_cnt[ch] <= '0;
                rep_cnt[ch]  <= '0;
            end
            rep_first <= '0;
            out_q     <= '0;
            press_q   <= '0;
            release_q <= '0;
            repeat_q  <= '0;
        end else begin
            for (int ch = 0; ch < CHANNELS; ch++) begin
                sync_q[ch] <= {sync_q[ch][SYNC_STAGES-2:0], bus.button_input[ch]};

                press_q[ch]   <= 1'b0;
                release_q[ch] <= 1'b0;
                repeat_q[ch]  <= 1'b0;

                if (sync_q[ch][SYNC_STAGES-1] == out_q[ch]) begin
                    stab_cnt[ch] <= '0;
                end else if (!accept[ch]) begin
                    stab_cnt[ch] <= stab_cnt[ch] + 1'b1;
                end else begin
                    stab_cnt[ch]  <= '0;
                    out_q[ch]     <= sync_q[ch][SYNC_STAGES-1];
                    press_q[ch]   <= sync_q[ch][SYNC_STAGES-1];
                    release_q[ch] <= ~sync_q[ch][SYNC_STAGES-1];
                end

                // Any acceptance rearms the delay phase; a release acceptance also
                // suppresses a repeat that would otherwise land on the same edge.
                if (accept[ch]) begin
                    rep_cnt[ch]   <= '0;
                    rep_first[ch] <= 1'b1;
                end else if (out_q[ch] && REPEAT_EN) begin
                    if (rep_due[ch]) begin
                        repeat_q[ch]  <= 1'b1;
                        rep_cnt[ch]   <= '0;
                        rep_first[ch] <= 1'b0;
                    end else if (rep_cnt[ch] != '1) begin
                        rep_cnt[ch] <= rep_cnt[ch] + 1'b1;
                    end
                end
            end
        end
    end

    assign bus.button_output   = out_q;
    assign bus.button_pressed  = press_q;
    assign bus.button_released = release_q;
    assign bus.button_repeat   = repeat_q;

endmodule
